// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multiply/divide unit.
// FSM state encoding, op codes, default width and count width helper.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MD_WIDTH = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int MD_CNT_W = cnt_w(MD_WIDTH);

endpackage

// File: rtl/multdiv_signfix.sv
// multdiv_signfix: conditional two's-complement negation of an N-bit value.
// Used for operand magnitudes and for result sign correction.
module multdiv_signfix #(
  parameter int N = 32
) (
  input  logic         i_neg,
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide into HI/LO.
// Optional macro MULTDIV_UNSIGNED_EN honours is_unsigned (multu/divu).
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int W  = WIDTH;
  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_dz;
  logic             r_neg_p;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic             w_b_zero;
  logic [W-1:0]     w_mag_a;
  logic [W-1:0]     w_mag_b;
  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_quo;
  logic [W-1:0]     w_rem;
  logic [W:0]       w_sum;
  logic [2*W-1:0]   w_mul_nx;
  logic [W:0]       w_sh;
  logic [W:0]       w_diff;
  logic [2*W-1:0]   w_div_nx;

`ifdef MULTDIV_UNSIGNED_EN
  assign w_signed = ~is_unsigned;
`else
  logic w_unused_unsigned;
  assign w_unused_unsigned = is_unsigned;
  assign w_signed = 1'b1;
`endif

  assign w_sa     = w_signed & op_a[W-1];
  assign w_sb     = w_signed & op_b[W-1];
  assign w_b_zero = (op_b == '0);

  multdiv_signfix #(.N(W)) u_mag_a (
    .i_neg (w_sa),
    .i_val (op_a),
    .o_val (w_mag_a)
  );

  multdiv_signfix #(.N(W)) u_mag_b (
    .i_neg (w_sb),
    .i_val (op_b),
    .o_val (w_mag_b)
  );

  multdiv_signfix #(.N(2*W)) u_fix_p (
    .i_neg (r_neg_p),
    .i_val (r_acc),
    .o_val (w_prod)
  );

  multdiv_signfix #(.N(W)) u_fix_q (
    .i_neg (r_neg_q),
    .i_val (r_acc[W-1:0]),
    .o_val (w_quo)
  );

  multdiv_signfix #(.N(W)) u_fix_r (
    .i_neg (r_neg_r),
    .i_val (r_acc[2*W-1:W]),
    .o_val (w_rem)
  );

  // one multiply step: add multiplicand on LSB, shift right
  assign w_sum = {1'b0, r_acc[2*W-1:W]}
               + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
  assign w_mul_nx = {w_sum, r_acc[W-1:1]};

  // one restoring divide step: shift left, trial subtract
  assign w_sh   = r_acc[2*W-1:W-1];
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_div_nx = w_diff[W]
                  ? {w_sh[W-1:0], r_acc[W-2:0], 1'b0}
                  : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

  // state register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start)
              w_next = (op == OP_DIV && w_b_zero) ? FIX : CALC;
      CALC: if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // operand latch, iteration datapath and HI/LO write-back
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op       <= OP_MULT;
      r_dz       <= 1'b0;
      r_neg_p    <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_b        <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (start) begin
          r_op  <= op;
          r_cnt <= CW'(W-1);
          if (op == OP_DIV) begin
            r_b     <= w_mag_b;
            r_dz    <= w_b_zero;
            r_neg_p <= 1'b0;
            r_neg_q <= ~w_b_zero & (w_sa ^ w_sb);
            r_neg_r <= w_sa;
            // zero divisor: remainder restores op_a, quotient all ones
            r_acc   <= w_b_zero ? {w_mag_a, {W{1'b1}}}
                                : {{W{1'b0}}, w_mag_a};
          end else begin
            r_b     <= w_mag_a;
            r_dz    <= 1'b0;
            r_neg_p <= w_sa ^ w_sb;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= {{W{1'b0}}, w_mag_b};
          end
        end
        CALC: begin
          r_acc <= (r_op == OP_DIV) ? w_div_nx : w_mul_nx;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_op == OP_MULT) begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end else begin
            r_hi       <= w_rem;
            r_lo       <= w_quo;
            r_div_zero <= r_dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Define MULTDIV_UNSIGNED_EN for both DUT and bench to test multu/divu.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        is_unsigned = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  logic m_dz = 1'b0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .is_unsigned (is_unsigned),
    .op_a        (op_a),
    .op_b        (op_b),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  function automatic exp_t model(input logic o, input logic u,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        r;
    logic        s;
    logic [63:0] ea, eb, p, q, m;
`ifdef MULTDIV_UNSIGNED_EN
    s = ~u;
`else
    s = 1'b1 | u;
`endif
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    r.lat = 33;
    if (!o) begin
      p = ea * eb;
      r.hi = p[63:32]; r.lo = p[31:0]; r.dz = m_dz;
    end else if (b == 0) begin
      r.hi = a; r.lo = 32'hFFFFFFFF; r.dz = 1'b1; r.lat = 1;
    end else begin
      q = $signed(ea) / $signed(eb);
      m = $signed(ea) % $signed(eb);
      r.hi = m[31:0]; r.lo = q[31:0]; r.dz = 1'b0;
    end
    return r;
  endfunction

  // drives a start pulse (ending #1 after edge 0) and records the expectation
  task automatic issue(input logic o, input logic u,
                       input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    op = o; is_unsigned = u; op_a = a; op_b = b;
    start = 1'b1;
    sb.push_back(e);
    m_dz = e.dz;
    @(posedge clock); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; op = 1'($urandom);
  endtask

  // returns cycles after edge 0 until done (-1 on timeout) and busy count
  task automatic wait_done(output int n, output int bc);
    n = -1; bc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (done) begin n = i; break; end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
    checks++; if (hi !== 32'h0) $display("FAIL rst_hi got %h want 0", hi); else passed++;
    checks++; if (lo !== 32'h0) $display("FAIL rst_lo got %h want 0", lo); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL rst_dz got %b want 0", div_zero); else passed++;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mult();
    exp_t e, g;
    int n, bc;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin a = 32'd7; b = 32'hFFFFFFFD; e = '{32'hFFFFFFFF, 32'hFFFFFFEB, m_dz, 33}; end
        1: begin a = 32'h80000000; b = a; e = '{32'h40000000, 32'h0, m_dz, 33}; end
        2: begin a = 32'h7FFFFFFF; b = 32'h80000000; e = '{32'hC0000000, 32'h80000000, m_dz, 33}; end
        default: begin a = $urandom; b = $urandom; e = model(1'b0, 1'b0, a, b); end
      endcase
      issue(1'b0, 1'b0, a, b, e);
      checks++; if (busy !== 1'b1) $display("FAIL mul_busy0 got %b want 1", busy); else passed++;
      wait_done(n, bc);
      g = sb.pop_front();
      checks++; if (hi !== g.hi) $display("FAIL mul_hi a=%h b=%h got %h want %h", a, b, hi, g.hi); else passed++;
      checks++; if (lo !== g.lo) $display("FAIL mul_lo a=%h b=%h got %h want %h", a, b, lo, g.lo); else passed++;
      checks++; if (div_zero !== g.dz) $display("FAIL mul_dz got %b want %b", div_zero, g.dz); else passed++;
      checks++; if (n !== g.lat) $display("FAIL mul_lat got %0d want %0d", n, g.lat); else passed++;
      checks++; if (bc !== g.lat - 1) $display("FAIL mul_busy got %0d want %0d", bc, g.lat - 1); else passed++;
      @(posedge clock); #1;
      checks++; if (done !== 1'b0) $display("FAIL mul_done_pulse got %b want 0", done); else passed++;
    end
  endtask

  task automatic test_div();
    exp_t e, g;
    int n, bc;
    logic [31:0] a, b;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin a = 32'hFFFFFFF9; b = 32'd2; e = '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33}; end
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; e = '{32'h0, 32'h80000000, 1'b0, 33}; end
        2: begin a = 32'd10; b = 32'd3; e = '{32'd1, 32'd3, 1'b0, 33}; end
        3: begin a = 32'd7; b = 32'hFFFFFFFE; e = '{32'd1, 32'hFFFFFFFD, 1'b0, 33}; end
        default: begin
          a = $urandom;
          b = ($urandom >> $urandom_range(0, 30)) | 32'h1;
          e = model(1'b1, 1'b0, a, b);
        end
      endcase
      issue(1'b1, 1'b0, a, b, e);
      wait_done(n, bc);
      g = sb.pop_front();
      checks++; if (hi !== g.hi) $display("FAIL div_hi a=%h b=%h got %h want %h", a, b, hi, g.hi); else passed++;
      checks++; if (lo !== g.lo) $display("FAIL div_lo a=%h b=%h got %h want %h", a, b, lo, g.lo); else passed++;
      checks++; if (div_zero !== g.dz) $display("FAIL div_dz got %b want %b", div_zero, g.dz); else passed++;
      checks++; if (n !== g.lat) $display("FAIL div_lat got %0d want %0d", n, g.lat); else passed++;
    end
  endtask

  task automatic test_div_zero();
    exp_t e, g;
    int n, bc;
    logic o;
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin o = 1'b1; a = 32'd5; b = 32'd0; e = '{32'd5, 32'hFFFFFFFF, 1'b1, 1}; end
        1: begin o = 1'b0; a = 32'd3; b = 32'd4; e = '{32'd0, 32'd12, 1'b1, 33}; end
        2: begin o = 1'b1; a = 32'd10; b = 32'd3; e = '{32'd1, 32'd3, 1'b0, 33}; end
        default: begin o = 1'b1; a = 32'hFFFFFFF7; b = 32'd0; e = '{32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, 1}; end
      endcase
      issue(o, 1'b0, a, b, e);
      checks++; if (busy !== 1'b1) $display("FAIL dz_busy0 got %b want 1", busy); else passed++;
      wait_done(n, bc);
      g = sb.pop_front();
      checks++; if (hi !== g.hi) $display("FAIL dz_hi step=%0d got %h want %h", i, hi, g.hi); else passed++;
      checks++; if (lo !== g.lo) $display("FAIL dz_lo step=%0d got %h want %h", i, lo, g.lo); else passed++;
      checks++; if (div_zero !== g.dz) $display("FAIL dz_flag step=%0d got %b want %b", i, div_zero, g.dz); else passed++;
      checks++; if (n !== g.lat) $display("FAIL dz_lat step=%0d got %0d want %0d", i, n, g.lat); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t g;
    int n, bc;
    logic [31:0] a, b;
    a = 32'd1000; b = 32'hFFFFFF9C;
    issue(1'b0, 1'b0, a, b, model(1'b0, 1'b0, a, b));
    wait_done(n, bc);
    g = sb.pop_front();
    checks++; if (lo !== g.lo || hi !== g.hi) $display("FAIL b2b_first got %h_%h want %h_%h", hi, lo, g.hi, g.lo); else passed++;
    a = 32'hFFFF0001; b = 32'd77;
    issue(1'b1, 1'b0, a, b, model(1'b1, 1'b0, a, b));
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy %b want 1", busy); else passed++;
    wait_done(n, bc);
    g = sb.pop_front();
    checks++; if (hi !== g.hi) $display("FAIL b2b_hi got %h want %h", hi, g.hi); else passed++;
    checks++; if (lo !== g.lo) $display("FAIL b2b_lo got %h want %h", lo, g.lo); else passed++;
    checks++; if (n !== g.lat) $display("FAIL b2b_lat got %0d want %0d", n, g.lat); else passed++;
  endtask

  task automatic test_busy_ignore();
    exp_t g;
    int n, bc;
    issue(1'b0, 1'b0, 32'd6, 32'd7, '{32'd0, 32'd42, m_dz, 33});
    repeat (4) @(posedge clock);
    #1;
    op = 1'b1; op_a = 32'd100; op_b = 32'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(n, bc);
    g = sb.pop_front();
    checks++; if (hi !== g.hi) $display("FAIL ign_hi got %h want %h", hi, g.hi); else passed++;
    checks++; if (lo !== g.lo) $display("FAIL ign_lo got %h want %h", lo, g.lo); else passed++;
    checks++; if (div_zero !== g.dz) $display("FAIL ign_dz got %b want %b", div_zero, g.dz); else passed++;
    checks++; if (n + 5 !== g.lat) $display("FAIL ign_lat got %0d want %0d", n + 5, g.lat); else passed++;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) $display("FAIL ign_idle got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int late;
    issue(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0,
          model(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0));
    repeat (4) @(posedge clock);
    #1;
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rmid_done got %b want 0", done); else passed++;
    checks++; if (hi !== 32'h0) $display("FAIL rmid_hi got %h want 0", hi); else passed++;
    checks++; if (lo !== 32'h0) $display("FAIL rmid_lo got %h want 0", lo); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL rmid_dz got %b want 0", div_zero); else passed++;
    reset = 1'b1;
    sb.delete();
    m_dz = 1'b0;
    late = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done || busy) late++;
    end
    checks++; if (late !== 0) $display("FAIL rmid_no_result got %0d active cycles want 0", late); else passed++;
  endtask

  task automatic test_unsigned();
    exp_t e, g;
    int n, bc;
    logic o, u;
    for (int i = 0; i < 3; i++) begin
      case (i)
`ifdef MULTDIV_UNSIGNED_EN
        0: begin o = 1'b0; u = 1'b1; e = '{32'h1, 32'hFFFFFFFE, m_dz, 33}; end
        1: begin o = 1'b1; u = 1'b1; e = '{32'h1, 32'h7FFFFFFF, 1'b0, 33}; end
`else
        0: begin o = 1'b0; u = 1'b1; e = '{32'hFFFFFFFF, 32'hFFFFFFFE, m_dz, 33}; end
        1: begin o = 1'b1; u = 1'b1; e = '{32'hFFFFFFFF, 32'h0, 1'b0, 33}; end
`endif
        default: begin o = 1'b0; u = 1'b0; e = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33}; end
      endcase
      issue(o, u, 32'hFFFFFFFF, 32'd2, e);
      wait_done(n, bc);
      g = sb.pop_front();
      checks++; if (hi !== g.hi) $display("FAIL uns_hi step=%0d got %h want %h", i, hi, g.hi); else passed++;
      checks++; if (lo !== g.lo) $display("FAIL uns_lo step=%0d got %h want %h", i, lo, g.lo); else passed++;
      checks++; if (n !== g.lat) $display("FAIL uns_lat step=%0d got %0d want %0d", i, n, g.lat); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_unsigned();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the multicycle CPU. It takes operands from the A/B register outputs when the control unit pulses `start`. It computes a 64-bit product, or a quotient and remainder, over 32 compute cycles. Results are held in internal HI/LO registers, which feed the memory-to-register write-back mux for `mfhi`/`mflo`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only while idle.
- `op`  in  1  0 = multiply, 1 = divide.
- `is_unsigned`  in  1  unsigned operation; honoured only with `MULTDIV_UNSIGNED_EN`.
- `op_a`  in  WIDTH  multiplicand / dividend.
- `op_b`  in  WIDTH  multiplier / divisor.
- `hi`  out  WIDTH  product[63:32] / remainder.
- `lo`  out  WIDTH  product[31:0] / quotient.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `div_zero`  out  1  sticky flag: last divide had a zero divisor.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE + `start`:
  - Latch the magnitudes |op_a| and |op_b|, the result-sign flags and `op`.
  - Load count = WIDTH-1.
  - Divide with op_b == 0: go to FIX with the dz flag set. Otherwise go to CALC.
- CALC, one bit per cycle:
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division, remainder/quotient shift register.
  - Count decrements; at count == 0 go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Divide: quotient is negative if the signs differ; remainder takes the sign of the dividend.
  - Write HI/LO, pulse `done`, update `div_zero` (set on dz, cleared on any other completed divide, unchanged by multiply), return to IDLE.
- Divide by zero: `hi` = op_a, `lo` = all ones, `div_zero` = 1.
- 0x80000000 / -1: `lo` = 0x80000000, `hi` = 0, no flag.
- HI/LO hold their values until the next completion; they are unchanged while busy.
- `start` while busy is ignored; operand changes during an operation are ignored.
- Reset (any state, including mid-operation): state IDLE, `hi` = `lo` = 0, `busy` = `done` = `div_zero` = 0, count = 0.

## Timing
- `start` is sampled at edge 0.
- Normal operation:
  - CALC occupies edges 1..32; FIX is entered at edge 32.
  - `hi`/`lo` update and `done` rises at edge 33. Latency is 33 cycles.
  - `busy` is high after edges 0..32 and low from edge 33.
- Divide by zero: FIX is entered at edge 0; `done` rises at edge 1.
- `done` is high for exactly one cycle. A `start` presented during the `done` cycle is accepted (back-to-back operation).
- No combinational path from inputs to outputs.

## Configuration
- `MULTDIV_UNSIGNED_EN` defined:
  - `is_unsigned` = 1 skips magnitude conversion and sign correction.
  - Operands are treated as unsigned (`multu`/`divu`).
- Undefined: `is_unsigned` is ignored and all operations are signed. The port remains present so the top level is unchanged.

## Structure
- Package `multdiv_pkg`:
  - State enum {IDLE, CALC, FIX}.
  - Op encoding constants OP_MULT = 0, OP_DIV = 1.
  - Default WIDTH = 32 and the count width `$clog2(WIDTH)`.
- One combinational sub-module, `multdiv_signfix`: conditional 2N-bit / N-bit negation, shared by operand-magnitude extraction and result correction.

## Test plan
- Multiply 7 × -3 (0xFFFFFFFD):
  - `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
  - `done` at edge 33; `busy` high for 33 cycles.
- Multiply 0x80000000 × 0x80000000: `hi` = 0x40000000, `lo` = 0x00000000.
- Divide -7 / 2:
  - `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF, `div_zero` = 0.
  - Divide 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- Divide 5 / 0:
  - `done` at edge 1, `hi` = 5, `lo` = 0xFFFFFFFF, `div_zero` = 1.
  - The flag stays 1 through a following multiply and clears after 10 / 3 (`lo` = 3, `hi` = 1).
- Start a multiply and pulse `start` with new operands at edge 5:
  - That second pulse is ignored.
  - Assert `reset` low at edge 10: `busy`, `done`, `hi`, `lo` all 0 next cycle, and the result is never delivered.
- With `MULTDIV_UNSIGNED_EN`:
  - 0xFFFFFFFF × 2 unsigned → `hi` = 1, `lo` = 0xFFFFFFFE.
  - 0xFFFFFFFF / 2 unsigned → `lo` = 0x7FFFFFFF, `hi` = 1.
  - Without the macro, the same multiply gives `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFE.
